// File: rtl/display_page_sel.sv
// Page selector feeding the 7-segment/LED display driver: debounced next/prev
// buttons plus an auto-scroll timer pick one of PAGES 32-bit debug words.
module display_page_sel #(
    parameter int CLK_FREQ    = 25,
    parameter int PAGES       = 8,
    parameter int DEBOUNCE_MS = 20,
    parameter int SCROLL_MS   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_next,
    input  logic                  btn_prev,
    input  logic                  auto_scroll,
    input  logic                  lz_blank,
    input  logic [32*PAGES-1:0]   page_data,
    output logic [7:0]            en,
    output logic [31:0]           data,
    output logic [7:0]            dot,
    output logic [15:0]           led
);

    localparam int DB_CNT = CLK_FREQ * DEBOUNCE_MS * 1000;
    localparam int SC_CNT = CLK_FREQ * SCROLL_MS * 1000;
    localparam int DBW    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int SCW    = (SC_CNT > 1) ? $clog2(SC_CNT) : 1;
    localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
    localparam logic [SCW-1:0] SC_LAST   = SCW'(SC_CNT - 1);
    localparam logic [PW-1:0]  PAGE_LAST = PW'(PAGES - 1);

    // Bit 0 = next, bit 1 = prev
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_prev, btn_next};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic           sync1_q;
            logic           sync2_q;
            logic           acc_q;
            logic           acc_d;
            logic [DBW-1:0] cnt_q;
            logic [DBW-1:0] cnt_d;
            logic           rise;

            // The counter only runs while the synced level disagrees with the
            // accepted level, so any return to agreement restarts the window.
            always_comb begin
                acc_d = acc_q;
                cnt_d = '0;
                rise  = 1'b0;
                if (sync2_q != acc_q) begin
                    if (cnt_q == DB_LAST) begin
                        acc_d = sync2_q;
                        rise  = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    acc_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign press[gi] = rise;
        end
    endgenerate

    logic [SCW-1:0] sc_cnt_q;
    logic [SCW-1:0] sc_cnt_d;
    logic           tick;

    // A manual press restarts the scroll period.
    always_comb begin
        sc_cnt_d = sc_cnt_q;
        tick     = auto_scroll && (sc_cnt_q == SC_LAST);
        if (!auto_scroll || (|press)) begin
            sc_cnt_d = '0;
        end else if (sc_cnt_q == SC_LAST) begin
            sc_cnt_d = '0;
        end else begin
            sc_cnt_d = sc_cnt_q + 1'b1;
        end
    end

    logic [PW-1:0] page_q;
    logic [PW-1:0] page_d;
    logic          step_fwd;
    logic          step_back;

    assign step_fwd  = (press[0] | tick) & ~press[1];
    assign step_back = press[1] & ~press[0] & ~tick;

    always_comb begin
        page_d = page_q;
        if (step_fwd) begin
            page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
        end else if (step_back) begin
            page_d = (page_q == '0) ? PAGE_LAST : page_q - 1'b1;
        end
    end

    logic [31:0] words [PAGES];
    logic [31:0] word_sel;
    logic [7:0]  nz;

    generate
        for (gi = 0; gi < PAGES; gi++) begin : g_word
            assign words[gi] = page_data[32*gi +: 32];
        end
        // nz[i] set when any nibble from i up to the top is nonzero
        for (gi = 0; gi < 8; gi++) begin : g_nz
            assign nz[gi] = |word_sel[31:4*gi];
        end
    endgenerate

    assign word_sel = words[page_q];

    logic [7:0]  en_q;
    logic [7:0]  en_d;
    logic [31:0] data_q;
    logic [7:0]  dot_q;
    logic [7:0]  dot_d;
    logic [15:0] led_q;
    logic [15:0] led_d;

    always_comb begin
        en_d  = lz_blank ? (nz | 8'h01) : 8'hFF;
        dot_d = 8'd1 << page_q;
        led_d = {auto_scroll, 11'd0, 4'(page_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_cnt_q <= '0;
            page_q   <= '0;
            en_q     <= 8'h00;
            data_q   <= 32'd0;
            dot_q    <= 8'h00;
            led_q    <= 16'h0000;
        end else begin
            sc_cnt_q <= sc_cnt_d;
            page_q   <= page_d;
            en_q     <= en_d;
            data_q   <= word_sel;
            dot_q    <= dot_d;
            led_q    <= led_d;
        end
    end

    assign en   = en_q;
    assign data = data_q;
    assign dot  = dot_q;
    assign led  = led_q;

endmodule

// File: tb/tb_display_page_sel.sv
// Bench for display_page_sel: scenario tasks with randomized presses and words,
// checked against a page-number model and a digit-count model of the display.
module tb_display_page_sel;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_prev = 1'b0;
    logic         auto_scroll = 1'b0;
    logic         lz_blank = 1'b0;
    logic [255:0] page_data;
    logic [7:0]   en;
    logic [31:0]  data;
    logic [7:0]   dot;
    logic [15:0]  led;

    logic [31:0] words [8];
    int checks = 0;
    int errors = 0;
    int exp_page = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < 8; p++) page_data[32*p +: 32] = words[p];
    end

    display_page_sel #(
        .CLK_FREQ(1), .PAGES(8), .DEBOUNCE_MS(1), .SCROLL_MS(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_scroll(auto_scroll), .lz_blank(lz_blank), .page_data(page_data),
        .en(en), .data(data), .dot(dot), .led(led)
    );

    // Number of displayed digits = position of the highest nonzero nibble + 1.
    function automatic logic [7:0] model_en(logic [31:0] w, logic lzb);
        int digits;
        digits = 1;
        if (!lzb) return 8'hFF;
        for (int n = 7; n >= 0; n--) begin
            if (w[4*n +: 4] != 4'h0) begin
                digits = n + 1;
                break;
            end
        end
        return 8'((1 << digits) - 1);
    endfunction

    function automatic int model_step(int p, int fwd);
        return fwd ? (p + 1) % 8 : (p + 7) % 8;
    endfunction

    task automatic tick_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(int which, int hold);
        if (which == 0) btn_next = 1'b1; else btn_prev = 1'b1;
        tick_n(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick_n(1100);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick_n(3);
        checks++;
        if ({en, data, dot, led} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hold: en=%h data=%h dot=%h led=%h required all 0", en, data, dot, led);
        end
        rst = 1'b0;
        exp_page = 0;
        tick_n(2);
        checks++;
        if (data !== words[0] || dot !== 8'h01 || en !== 8'hFF || led !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release: data=%h dot=%h en=%h led=%h required 0/01/ff/0000", data, dot, en, led);
        end
        $display("test_reset: data=%h dot=%h en=%h", data, dot, en);
    endtask

    task automatic test_next;
        for (int k = 0; k < 3; k++) begin
            press_btn(0, 1200);
            exp_page = model_step(exp_page, 1);
        end
        checks++;
        if (data !== words[exp_page] || dot !== 8'(1 << exp_page) || led !== 16'(exp_page) || en !== 8'hFF) begin
            errors++;
            $display("FAIL next3: data=%h dot=%h led=%h en=%h required page %0d", data, dot, led, en, exp_page);
        end
        $display("test_next: page=%0d data=%h dot=%h led=%h", exp_page, data, dot, led);
    endtask

    task automatic test_prev_wrap;
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        exp_page = 0;
        tick_n(2);
        press_btn(1, 1200);
        exp_page = model_step(exp_page, 0);
        checks++;
        if (dot !== 8'(1 << exp_page) || data !== words[exp_page]) begin
            errors++;
            $display("FAIL prev_wrap: dot=%h data=%h required page %0d", dot, data, exp_page);
        end
        $display("test_prev_wrap: prev -> page %0d dot=%h", exp_page, dot);
        for (int k = 0; k < 8; k++) begin
            press_btn(0, $urandom_range(1050, 1300));
            exp_page = model_step(exp_page, 1);
            checks++;
            if (dot !== 8'(1 << exp_page)) begin
                errors++;
                $display("FAIL next_wrap_%0d: dot=%h required %h", k, dot, 8'(1 << exp_page));
            end
            $display("test_prev_wrap: next #%0d -> page %0d dot=%h", k, exp_page, dot);
        end
    endtask

    task automatic test_glitch;
        btn_next = 1'b1;
        tick_n(500);
        btn_next = 1'b0;
        tick_n(1200);
        checks++;
        if (dot !== 8'(1 << exp_page)) begin
            errors++;
            $display("FAIL glitch: dot=%h required %h", dot, 8'(1 << exp_page));
        end
        $display("test_glitch: 500-cycle glitch, page %0d", exp_page);
        for (int k = 0; k < 10; k++) begin
            btn_next = 1'b1;
            tick_n(100);
            btn_next = 1'b0;
            tick_n(100);
        end
        press_btn(0, 1200);
        exp_page = model_step(exp_page, 1);
        checks++;
        if (dot !== 8'(1 << exp_page) || data !== words[exp_page]) begin
            errors++;
            $display("FAIL bounce: dot=%h data=%h required page %0d", dot, data, exp_page);
        end
        $display("test_glitch: bounce then hold -> page %0d", exp_page);
    endtask

    task automatic test_random_walk;
        for (int k = 0; k < 3; k++) begin
            int dir;
            dir = int'($urandom_range(0, 1));
            press_btn(dir, $urandom_range(1050, 1300));
            exp_page = model_step(exp_page, (dir == 0) ? 1 : 0);
            checks++;
            if (dot !== 8'(1 << exp_page) || data !== words[exp_page]) begin
                errors++;
                $display("FAIL walk_%0d: dot=%h data=%h required page %0d", k, dot, data, exp_page);
            end
            $display("test_random_walk: %s -> page %0d", (dir == 0) ? "next" : "prev", exp_page);
        end
    endtask

    task automatic test_scroll;
        logic [7:0] last;
        int changes;
        int first;
        changes = 0;
        first = -1;
        last = dot;
        auto_scroll = 1'b1;
        for (int i = 1; i <= 12010; i++) begin
            @(negedge clk);
            if (i == 12000) auto_scroll = 1'b0;
            if (i == 10) begin
                checks++;
                if (led[15] !== 1'b1) begin
                    errors++;
                    $display("FAIL scroll_led15: led=%h required bit15=1", led);
                end
            end
            if (dot !== last) begin
                changes++;
                if (first < 0) first = i;
                last = dot;
            end
        end
        exp_page = (exp_page + 3) % 8;
        checks++;
        if (changes != 3 || first != 4001) begin
            errors++;
            $display("FAIL scroll_count: advances=%0d first=%0d required 3 advances first 4001", changes, first);
        end
        checks++;
        if (dot !== 8'(1 << exp_page) || led !== 16'(exp_page)) begin
            errors++;
            $display("FAIL scroll_page: dot=%h led=%h required page %0d", dot, led, exp_page);
        end
        $display("test_scroll: advances=%0d first=%0d page=%0d", changes, first, exp_page);
    endtask

    task automatic test_scroll_restart;
        logic [7:0] last;
        int t [$];
        last = dot;
        auto_scroll = 1'b1;
        for (int i = 1; i <= 9000; i++) begin
            @(negedge clk);
            if (i == 2000) btn_next = 1'b1;
            if (i == 3200) btn_next = 1'b0;
            if (dot !== last) begin
                t.push_back(i);
                last = dot;
            end
        end
        auto_scroll = 1'b0;
        tick_n(2);
        exp_page = (exp_page + 2) % 8;
        checks++;
        if (t.size() != 2) begin
            errors++;
            $display("FAIL restart_count: advances=%0d required 2", t.size());
        end else begin
            checks++;
            if (t[0] < 3000 || t[0] > 3010 || t[1] - t[0] != 4000) begin
                errors++;
                $display("FAIL restart_timing: press_at=%0d tick_at=%0d required tick = press+4000", t[0], t[1]);
            end
            $display("test_scroll_restart: press_at=%0d tick_at=%0d", t[0], t[1]);
        end
        checks++;
        if (dot !== 8'(1 << exp_page)) begin
            errors++;
            $display("FAIL restart_page: dot=%h required %h", dot, 8'(1 << exp_page));
        end
    endtask

    task automatic test_lz_blank;
        logic [31:0] saved;
        logic [31:0] vec [$];
        saved = words[exp_page];
        vec = '{32'h0000_0000, 32'h0000_0A05, 32'h8000_0000};
        for (int k = 0; k < 10; k++) begin
            int sh;
            logic [31:0] w;
            w = $urandom;
            sh = int'($urandom_range(0, 8));
            vec.push_back((sh == 8) ? 32'd0 : (w >> (4 * sh)));
        end
        lz_blank = 1'b1;
        foreach (vec[k]) begin
            words[exp_page] = vec[k];
            tick_n(2);
            checks++;
            if (en !== model_en(vec[k], 1'b1) || data !== vec[k]) begin
                errors++;
                $display("FAIL lz_%0d: word=%h en=%h data=%h required en=%h", k, vec[k], en, data, model_en(vec[k], 1'b1));
            end
            $display("test_lz_blank: word=%h en=%h", vec[k], en);
        end
        lz_blank = 1'b0;
        tick_n(2);
        checks++;
        if (en !== 8'hFF) begin
            errors++;
            $display("FAIL lz_off: en=%h required ff", en);
        end
        words[exp_page] = saved;
        tick_n(2);
    endtask

    task automatic test_reset_mid;
        logic [7:0] last;
        int changes;
        btn_next = 1'b1;
        tick_n(500);
        rst = 1'b1;
        tick_n(1);
        checks++;
        if ({en, data, dot, led} !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: en=%h data=%h dot=%h led=%h required all 0", en, data, dot, led);
        end
        btn_next = 1'b0;
        tick_n(2);
        rst = 1'b0;
        exp_page = 0;
        tick_n(1500);
        checks++;
        if (dot !== 8'h01 || data !== words[0]) begin
            errors++;
            $display("FAIL rst_mid_debounce: dot=%h data=%h required page 0", dot, data);
        end
        $display("test_reset_mid: debounce aborted, dot=%h", dot);
        auto_scroll = 1'b1;
        tick_n(3000);
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
        changes = 0;
        tick_n(1);
        last = dot;
        for (int i = 0; i < 3985; i++) begin
            @(negedge clk);
            if (dot !== last) changes++;
        end
        checks++;
        if (changes != 0) begin
            errors++;
            $display("FAIL rst_mid_scroll: early advances=%0d required 0", changes);
        end
        tick_n(20);
        auto_scroll = 1'b0;
        exp_page = 1;
        tick_n(2);
        checks++;
        if (dot !== 8'h02) begin
            errors++;
            $display("FAIL rst_mid_scroll_tick: dot=%h required 02", dot);
        end
        $display("test_reset_mid: scroll restarted, dot=%h", dot);
    endtask

    initial begin
        for (int p = 0; p < 8; p++) words[p] = 32'h1111_1111 * p;
        test_reset();
        test_next();
        test_prev_wrap();
        test_glitch();
        test_random_walk();
        test_scroll();
        test_scroll_restart();
        test_lz_blank();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
